l1_port_arbiter: RTL and testbench

- Shares the single-port on-chip L1 BRAM (3072 x 32-bit words) between the CPU instruction-fetch path and the CPU data bus.
- Sits between the riscv64 core and the BRAM, on CLOCK_50.
- Per-cycle arbitration: data has priority, with a starvation guard for fetch.
- Registered read-response pipeline tagged by owner; address/alignment error responses.

---
 rtl/l1_arb_pkg.sv | 19 +
 rtl/l1_starve_cnt.sv | 26 ++
 rtl/l1_port_arbiter.sv | 117 +++++++++++
 tb/tb_l1_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_arb_pkg.sv
// Shared owner type, default sizing and the byte-swap helper for the L1 port arbiter.
package l1_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int DEF_MEM_WORDS  = 3072;
    localparam int DEF_ADDR_W     = 12;
    localparam int DEF_STARVE_MAX = 4;

    // Reverses byte order so a little-endian memory word reads in instruction order.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/l1_starve_cnt.sv
// Saturating count of consecutive fetch denials; at_max tells the arbiter to let fetch win.
module l1_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [3:0] count;

    assign at_max = (count == 4'(MAX));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/l1_port_arbiter.sv
// Shares the single-port L1 BRAM between instruction fetch and the data bus (data first, fetch starvation guard).
// Define FETCH_BSWAP_EN to byte-reverse fetch read data into instruction order.
module l1_port_arbiter
    import l1_arb_pkg::*;
#(
    parameter int MEM_WORDS  = DEF_MEM_WORDS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [63:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [63:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 2;

    logic        if_legal;
    logic        d_legal;
    logic        starve_max;
    logic        grant_if;
    logic        grant_d;
    owner_t      resp_own;
    logic        resp_err;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic [31:0] if_word;

    assign if_legal = (if_addr[1:0] == 2'b00) && (if_addr < MEM_BYTES);
    assign d_legal  = (d_addr[1:0] == 2'b00) && (d_addr < MEM_BYTES);

    // Data normally wins; a fetch that has been denied STARVE_MAX times in a row takes the port.
    assign grant_d  = d_req && !(if_req && starve_max);
    assign grant_if = if_req && !grant_d;
    assign if_gnt   = grant_if;
    assign d_gnt    = grant_d;

    l1_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (if_req && !grant_if),
        .clr     (!if_req || grant_if),
        .at_max  (starve_max)
    );

    // Illegal requests are still granted so the requester moves on, but never reach the BRAM.
    assign mem_en    = (grant_d && d_legal) || (grant_if && if_legal);
    assign mem_we    = grant_d && d_legal && d_we;
    assign mem_addr  = grant_d ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
    assign mem_wdata = d_wdata;

`ifdef FETCH_BSWAP_EN
    assign if_word = bswap32(mem_rdata);
`else
    assign if_word = mem_rdata;
`endif

    assign if_rvalid = (resp_own == OWN_IF);
    assign d_rvalid  = (resp_own == OWN_D);
    assign if_err    = if_rvalid && resp_err;
    assign d_err     = d_rvalid && resp_err;

    // BRAM data arrives in the response cycle; the non-owner keeps showing its last word.
    always_comb begin
        if_rdata = if_rdata_q;
        d_rdata  = d_rdata_q;
        if (resp_own == OWN_IF) begin
            if_rdata = resp_err ? 32'h0 : if_word;
        end
        if (resp_own == OWN_D) begin
            d_rdata = resp_err ? 32'h0 : mem_rdata;
        end
    end

    // Legal data writes complete at grant, so only reads and errors earn a response slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_own   <= OWN_NONE;
            resp_err   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_rdata_q <= if_rdata;
            d_rdata_q  <= d_rdata;
            if (grant_if) begin
                resp_own <= OWN_IF;
                resp_err <= !if_legal;
            end else if (grant_d && (!d_we || !d_legal)) begin
                resp_own <= OWN_D;
                resp_err <= !d_legal;
            end else begin
                resp_own <= OWN_NONE;
                resp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Self-checking bench for l1_port_arbiter: directed scenarios then random traffic against a reference model.
module tb_l1_port_arbiter;

    localparam int MEM_WORDS  = 3072;
    localparam int ADDR_W     = 12;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              if_req;
    logic [63:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;
    logic              d_req;
    logic              d_we;
    logic [63:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              preload_en;
    logic [31:0]       bram    [MEM_WORDS];
    logic [31:0]       ref_mem [MEM_WORDS];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: fetch denial streak, pending response, last word each side saw.
    int          starve;
    int          pend_own;
    logic [31:0] pend_data;
    logic        pend_err;
    logic [31:0] last_if;
    logic [31:0] last_d;

    always #10 clk = ~clk;

    l1_port_arbiter #(
        .MEM_WORDS  (MEM_WORDS),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h1300_0000;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous single-port BRAM: write-only on writes, registered read data otherwise.
    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < MEM_WORDS; i++) bram[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= bram[mem_addr];
        end
    end

    function automatic logic [31:0] fetch_view(input logic [31:0] w);
`ifdef FETCH_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic addr_ok(input logic [63:0] a);
        return (a % 4 == 0) && (a < 64'(MEM_WORDS) * 4);
    endfunction

    function automatic logic [63:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 64'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
        if (sel == 1) return 64'(MEM_WORDS) * 4 + 64'($urandom_range(0, 1023) * 4);
        if (sel == 2) return {$urandom_range(1, 255), 32'h0};
        if (sel == 3) return 64'($urandom_range(0, MEM_WORDS - 1) * 4);
        return 64'($urandom_range(0, 15) * 4);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, check grants/BRAM port and the previous grant's response, then advance the model.
    task automatic applyStimulus(input logic ir, input logic [63:0] ia, input logic dr, input logic dwe,
                                 input logic [63:0] da, input logic [31:0] dwd, input logic rst_n,
                                 output logic gi, output logic gd);
        logic ileg, dleg, exp_en;
        logic [31:0] exp_if, exp_d;
        int iidx, didx;
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        reset_n = rst_n;
        #5;
        ileg = addr_ok(ia);
        dleg = addr_ok(da);
        iidx = int'(ia[13:2]);
        didx = int'(da[13:2]);
        gd = dr && !(ir && starve == STARVE_MAX);
        gi = ir && !gd;
        exp_en = (gd && dleg) || (gi && ileg);
        checkOutput("if_gnt", 64'(if_gnt), 64'(gi));
        checkOutput("d_gnt", 64'(d_gnt), 64'(gd));
        checkOutput("mem_en", 64'(mem_en), 64'(exp_en));
        if (exp_en) begin
            checkOutput("mem_we", 64'(mem_we), 64'(gd && dwe));
            checkOutput("mem_addr", 64'(mem_addr), 64'(gd ? didx : iidx));
            if (gd && dwe) checkOutput("mem_wdata", 64'(mem_wdata), 64'(dwd));
        end
        exp_if = (pend_own == 1) ? pend_data : last_if;
        exp_d  = (pend_own == 2) ? pend_data : last_d;
        checkOutput("if_rvalid", 64'(if_rvalid), 64'(pend_own == 1));
        checkOutput("if_err", 64'(if_err), 64'(pend_own == 1 && pend_err));
        checkOutput("if_rdata", 64'(if_rdata), 64'(exp_if));
        checkOutput("d_rvalid", 64'(d_rvalid), 64'(pend_own == 2));
        checkOutput("d_err", 64'(d_err), 64'(pend_own == 2 && pend_err));
        checkOutput("d_rdata", 64'(d_rdata), 64'(exp_d));
        last_if = exp_if;
        last_d  = exp_d;
        @(posedge clk);
        pend_own  = 0;
        pend_err  = 1'b0;
        pend_data = 32'h0;
        if (gi) begin
            pend_own  = 1;
            pend_err  = !ileg;
            pend_data = ileg ? fetch_view(ref_mem[iidx]) : 32'h0;
        end else if (gd && (!dwe || !dleg)) begin
            pend_own  = 2;
            pend_err  = !dleg;
            pend_data = dleg ? ref_mem[didx] : 32'h0;
        end
        if (gd && dleg && dwe) ref_mem[didx] = dwd;
        if (!rst_n) begin
            starve   = 0;
            pend_own = 0;
            last_if  = 32'h0;
            last_d   = 32'h0;
        end else if (ir && !gi) begin
            starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
        end else begin
            starve = 0;
        end
        #1;
    endtask

    initial begin
        logic gi, gd;
        logic hold_if, hold_d;
        logic ir, dr, dwe;
        logic [63:0] ia, da;
        logic [31:0] dwd;

        reset_n    = 1'b0;
        preload_en = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        starve    = 0;
        pend_own  = 0;
        pend_data = 32'h0;
        pend_err  = 1'b0;
        last_if   = 32'h0;
        last_d    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        preload_en = 1'b0;

        // Reset state, then a fetch of word 4.
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1, gi, gd);
        applyStimulus(1'b1, 64'h10, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1, gi, gd);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1, gi, gd);

        // Both requesting: the fetch only breaks through after repeated denials.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 64'h20, 1'b1, 1'b0, 64'h100, 32'h0, 1'b1, gi, gd);
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1, gi, gd);

        // Write then immediate read of the same word.
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h200, 32'hDEAD_BEEF, 1'b1, gi, gd);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h200, 32'h0, 1'b1, gi, gd);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1, gi, gd);

        // Out-of-range and misaligned data reads, plus an illegal fetch.
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h3000, 32'h0, 1'b1, gi, gd);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h102, 32'h0, 1'b1, gi, gd);
        applyStimulus(1'b1, 64'h2FFD, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1, gi, gd);
        applyStimulus(1'b1, 64'h2FFC, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1, gi, gd);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1, gi, gd);

        // Build up some denials, then reset at a fetch grant edge.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 64'h40, 1'b1, 1'b0, 64'h44, 32'h0, 1'b1, gi, gd);
        end
        applyStimulus(1'b1, 64'h40, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0, gi, gd);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0, gi, gd);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1, gi, gd);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 64'h10, 1'b1, 1'b0, 64'h200, 32'h0, 1'b1, gi, gd);
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1, gi, gd);

        // Random traffic; requests are held with their payload until granted.
        hold_if = 1'b0;
        hold_d  = 1'b0;
        ir = 1'b0; ia = '0; dr = 1'b0; dwe = 1'b0; da = '0; dwd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!hold_if) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = rand_addr();
            end
            if (!hold_d) begin
                dr  = ($urandom_range(0, 3) != 0);
                dwe = ($urandom_range(0, 2) == 0);
                da  = rand_addr();
                dwd = $urandom;
            end
            applyStimulus(ir, ia, dr, dwe, da, dwd, 1'b1, gi, gd);
            hold_if = ir && !gi;
            hold_d  = dr && !gd;
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1, gi, gd);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
